// File: rtl/priv_trap_sequencer.sv
// Machine-mode trap/return sequencer: picks one trap source, drains the pipeline,
// applies the privileged CSR updates in one cycle, then redirects fetch.
module priv_trap_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            exc_valid_i,
  input  logic [3:0]      exc_code_i,
  input  logic [XLEN-1:0] exc_epc_i,
  input  logic [XLEN-1:0] exc_badaddr_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] commit_pc_i,
  input  logic            timer_int_i,
  input  logic            soft_int_i,
  input  logic            mstatus_ie_i,
  input  logic            mie_mtie_i,
  input  logic            mie_msie_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            pipe_drained_i,
  output logic            pipe_flush_o,
  output logic            busy_o,
  output logic            mcause_rup_o,
  output logic [XLEN-1:0] mcause_next_o,
  output logic            mepc_rup_o,
  output logic [XLEN-1:0] mepc_next_o,
  output logic            mbadaddr_rup_o,
  output logic [XLEN-1:0] mbadaddr_next_o,
  output logic            mstatus_ie_rup_o,
  output logic            mstatus_ie_next_o,
  output logic            insert_pc_o,
  output logic [XLEN-1:0] priv_pc_o
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_UPDATE, S_REDIRECT} state_e;

  state_e          state_q;
  logic            ret_q;
  logic            badv_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] bad_q;

  logic timer_en, soft_en, exc_badv;
  assign timer_en = timer_int_i & mie_mtie_i & mstatus_ie_i;
  assign soft_en  = soft_int_i  & mie_msie_i & mstatus_ie_i;
  // Only fetch/load/store address faults carry a meaningful bad address.
  assign exc_badv = exc_code_i inside {4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ret_q   <= 1'b0;
      badv_q  <= 1'b0;
      cause_q <= '0;
      epc_q   <= '0;
      bad_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (exc_valid_i) begin
            ret_q   <= 1'b0;
            cause_q <= {{(XLEN-4){1'b0}}, exc_code_i};
            epc_q   <= exc_epc_i;
            bad_q   <= exc_badaddr_i;
            badv_q  <= exc_badv;
            state_q <= S_FLUSH;
          end else if (timer_en) begin
            ret_q   <= 1'b0;
            cause_q <= {1'b1, {(XLEN-5){1'b0}}, 4'd7};
            epc_q   <= commit_pc_i;
            badv_q  <= 1'b0;
            state_q <= S_FLUSH;
          end else if (soft_en) begin
            ret_q   <= 1'b0;
            cause_q <= {1'b1, {(XLEN-5){1'b0}}, 4'd3};
            epc_q   <= commit_pc_i;
            badv_q  <= 1'b0;
            state_q <= S_FLUSH;
          end else if (mret_i) begin
            ret_q   <= 1'b1;
            badv_q  <= 1'b0;
            state_q <= S_FLUSH;
          end
        end
        S_FLUSH:    if (pipe_drained_i) state_q <= S_UPDATE;
        S_UPDATE:   state_q <= S_REDIRECT;
        S_REDIRECT: state_q <= S_IDLE;
        default:    state_q <= S_IDLE;
      endcase
    end
  end

  logic upd, trap_upd, redir;
  assign upd      = (state_q == S_UPDATE);
  assign trap_upd = upd & ~ret_q;
  assign redir    = (state_q == S_REDIRECT);

  assign busy_o            = (state_q != S_IDLE);
  assign pipe_flush_o      = (state_q != S_IDLE);
  assign mcause_rup_o      = trap_upd;
  assign mcause_next_o     = trap_upd ? cause_q : '0;
  assign mepc_rup_o        = trap_upd;
  assign mepc_next_o       = trap_upd ? epc_q : '0;
  assign mbadaddr_rup_o    = trap_upd & badv_q;
  assign mbadaddr_next_o   = (trap_upd & badv_q) ? bad_q : '0;
  assign mstatus_ie_rup_o  = upd;
  assign mstatus_ie_next_o = upd & ret_q;
  // mepc was written at the end of UPDATE, so reading it live here sees the new value.
  assign insert_pc_o       = redir;
  assign priv_pc_o         = redir ? (ret_q ? mepc_i : mtvec_i) : '0;

endmodule
